// File: rtl/fsmd_gray_codec.sv
// ---------------------------------------------------------------------------
// fsmd_gray_codec
//   Parametrised FSMD Gray-code codec. Each transaction is selected by mode:
//     mode = 0 : binary -> Gray, computed in a single CALC cycle.
//     mode = 1 : Gray -> binary, bit-serial from MSB to LSB, one bit per
//                CALC cycle (WIDTH-1 CALC cycles in total).
//   It uses the same start/done handshake as the older 4-bit FSMD converters.
//
// Parameters
//   WIDTH     data width in bits (WIDTH >= 2)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while idle
//   mode      0 = binary->Gray, 1 = Gray->binary (captured with start)
//   data_in   operand (captured with start)
//   data_out  result; updated on completion only, held otherwise
//   busy      high while a conversion is in progress
//   done      one-cycle completion pulse, in the first idle cycle after CALC
//   parity    ^data_out, registered with data_out (only when the macro
//             GRAY_CODEC_PARITY_EN is defined)
// ---------------------------------------------------------------------------
module fsmd_gray_codec #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
`ifdef GRAY_CODEC_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] op_r, op_n;
  logic             mode_r, mode_n;
  logic [WIDTH-1:0] acc_r, acc_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [WIDTH-1:0] data_out_n;
  logic             busy_n;
  logic             done_n;

  // One serial step of the Gray->binary recurrence: each binary bit is the
  // binary bit above it XOR the Gray bit at the same position.
  logic [WIDTH-1:0] acc_step;
  logic [IDX_W-1:0] idx_above;

  always_comb begin
    idx_above         = idx_r + 1'b1;
    acc_step          = acc_r;
    acc_step[idx_r]   = acc_r[idx_above] ^ op_r[idx_r];
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every variable gets a default here, so no path leaves one
    // unassigned and no latch is inferred.
    state_n    = state;
    op_n       = op_r;
    mode_n     = mode_r;
    acc_n      = acc_r;
    idx_n      = idx_r;
    data_out_n = data_out;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          op_n    = data_in;
          mode_n  = mode;
          state_n = CALC;
          if (mode) begin
            // The MSB of a Gray code equals the binary MSB, so seed it now.
            acc_n            = '0;
            acc_n[WIDTH-1]   = data_in[WIDTH-1];
            idx_n            = IDX_W'(WIDTH - 2);
          end
        end
      end

      CALC: begin
        if (!mode_r) begin
          data_out_n = op_r ^ (op_r >> 1);
          done_n     = 1'b1;
          state_n    = IDLE;
        end else begin
          acc_n = acc_step;
          if (idx_r == '0) begin
            // Last bit resolved: publish the complete word only now so a
            // partial accumulator never appears on data_out.
            data_out_n = acc_step;
            done_n     = 1'b1;
            state_n    = IDLE;
          end else begin
            idx_n = idx_r - 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n == CALC);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_r     <= '0;
      mode_r   <= 1'b0;
      acc_r    <= '0;
      idx_r    <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state    <= state_n;
      op_r     <= op_n;
      mode_r   <= mode_n;
      acc_r    <= acc_n;
      idx_r    <= idx_n;
      data_out <= data_out_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

`ifdef GRAY_CODEC_PARITY_EN
  // Parity follows data_out: it changes only on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (done_n) begin
      parity <= ^data_out_n;
    end
  end
`endif

endmodule

// File: tb/tb_fsmd_gray_codec.sv
// ---------------------------------------------------------------------------
// tb_fsmd_gray_codec
//   Bench for fsmd_gray_codec with two instances, WIDTH=4 and WIDTH=8.
//   It keeps a transaction-level reference model of each instance. The model
//   tracks the result value and the number of CALC cycles left, and every
//   cycle its outputs are compared with the DUT outputs. Directed cases also
//   check hand-computed literal results, latencies and busy lengths.
// ---------------------------------------------------------------------------
module tb_fsmd_gray_codec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;

  logic       s4 = 1'b0, m4 = 1'b0;
  logic [3:0] d4 = '0;
  logic [3:0] q4;
  logic       b4, dn4;

  logic       s8 = 1'b0, m8 = 1'b0;
  logic [7:0] d8 = '0;
  logic [7:0] q8;
  logic       b8, dn8;

`ifdef GRAY_CODEC_PARITY_EN
  logic       p4, p8;
`endif

  fsmd_gray_codec #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s4),
    .mode     (m4),
    .data_in  (d4),
    .data_out (q4),
    .busy     (b4),
    .done     (dn4)
`ifdef GRAY_CODEC_PARITY_EN
    ,
    .parity   (p4)
`endif
  );

  fsmd_gray_codec #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s8),
    .mode     (m8),
    .data_in  (d8),
    .data_out (q8),
    .busy     (b8),
    .done     (dn8)
`ifdef GRAY_CODEC_PARITY_EN
    ,
    .parity   (p8)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model (index 0: WIDTH=4, index 1: WIDTH=8)
  // ------------------------------------------------------------------
  logic [7:0] m_out  [2];
  logic [7:0] m_res  [2];
  int         m_left [2];
  logic       m_done [2];

  function automatic logic [7:0] gray_of(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit i is the XOR of all Gray bits at positions >= i.
  function automatic logic [7:0] bin_of(input logic [7:0] g);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k]  = '0;
      m_res[k]  = '0;
      m_left[k] = 0;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic s, input logic m,
                            input logic [7:0] d, input int w);
    if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        m_out[k]  = m_res[k];
        m_done[k] = 1'b1;
      end
    end else begin
      m_done[k] = 1'b0;
      if (s) begin
        m_res[k]  = m ? bin_of(d) : gray_of(d);
        m_left[k] = m ? w - 1 : 1;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, s4, m4, {4'b0000, d4}, 4);
      model_step(1, s8, m8, d8, 8);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("w4_data_out", {28'd0, q4}, {28'd0, m_out[0][3:0]});
    check("w4_busy",     {31'd0, b4}, {31'd0, (m_left[0] > 0)});
    check("w4_done",     {31'd0, dn4}, {31'd0, m_done[0]});
    check("w8_data_out", {24'd0, q8}, {24'd0, m_out[1]});
    check("w8_busy",     {31'd0, b8}, {31'd0, (m_left[1] > 0)});
    check("w8_done",     {31'd0, dn8}, {31'd0, m_done[1]});
`ifdef GRAY_CODEC_PARITY_EN
    check("w4_parity",   {31'd0, p4}, {31'd0, ^m_out[0]});
    check("w8_parity",   {31'd0, p8}, {31'd0, ^m_out[1]});
`endif
  end

  // ------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input int k, input logic m, input logic [7:0] d);
    if (k == 0) begin
      s4 = 1'b1; m4 = m; d4 = d[3:0];
    end else begin
      s8 = 1'b1; m8 = m; d8 = d;
    end
    step();
    s4 = 1'b0;
    s8 = 1'b0;
  endtask

  // Called one step after the start edge. lat counts edges until done
  // shows (-1 on timeout), and busy_cyc counts cycles with busy high.
  task automatic wait_done(input int k, input int budget, output int lat, output int busy_cyc);
    lat      = -1;
    busy_cyc = 0;
    for (int n = 1; n <= budget; n++) begin
      if ((k == 0) ? b4 : b8) busy_cyc++;
      step();
      if ((k == 0) ? dn4 : dn8) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, dones;
    logic [7:0] seen;

    // Reset state
    repeat (3) step();
    check("rst_w4_data_out", {28'd0, q4}, 32'h0);
    check("rst_w4_busy",     {31'd0, b4}, 32'h0);
    check("rst_w8_data_out", {24'd0, q8}, 32'h0);
    check("rst_w8_done",     {31'd0, dn8}, 32'h0);
    rst_n = 1'b1;
    step();

    // Case 1: W=4 binary->Gray 1010 -> 1111
    start_txn(0, 1'b0, 8'h0A);
    wait_done(0, 10, lat, bc);
    check("c1_latency", lat, 1);
    check("c1_result",  {28'd0, q4}, 32'hF);
`ifdef GRAY_CODEC_PARITY_EN
    check("c1_parity",  {31'd0, p4}, 32'h0);
`endif
    step();
    check("c1_done_one_cycle", {31'd0, dn4}, 32'h0);

    // Case 2: W=4 1101 -> 1011, then Gray->binary 1111 -> 1010
    start_txn(0, 1'b0, 8'h0D);
    wait_done(0, 10, lat, bc);
    check("c2a_result", {28'd0, q4}, 32'hB);
`ifdef GRAY_CODEC_PARITY_EN
    check("c2a_parity", {31'd0, p4}, 32'h1);
`endif
    step();
    start_txn(0, 1'b1, 8'h0F);
    wait_done(0, 10, lat, bc);
    check("c2b_latency", lat, 3);
    check("c2b_busy_cycles", bc, 3);
    check("c2b_result", {28'd0, q4}, 32'hA);

    // Case 3: W=8 Gray->binary FF -> AA, then back-to-back 80 -> FF
    step();
    start_txn(1, 1'b1, 8'hFF);
    wait_done(1, 20, lat, bc);
    check("c3a_latency", lat, 7);
    check("c3a_busy_cycles", bc, 7);
    check("c3a_result", {24'd0, q8}, 32'hAA);
`ifdef GRAY_CODEC_PARITY_EN
    check("c3a_parity", {31'd0, p8}, 32'h0);
`endif
    start_txn(1, 1'b1, 8'h80);
    check("c3b_no_gap_busy", {31'd0, b8}, 32'h1);
    check("c3b_held_result", {24'd0, q8}, 32'hAA);
    wait_done(1, 20, lat, bc);
    check("c3b_latency", lat, 7);
    check("c3b_result", {24'd0, q8}, 32'hFF);

    // Case 4: start pulsed during CALC cycle 3 is ignored
    step();
    start_txn(1, 1'b1, 8'h0F);
    step();
    step();
    s8 = 1'b1; m8 = 1'b1; d8 = 8'h00;
    step();
    s8 = 1'b0;
    dones = 0;
    seen  = '0;
    for (int n = 0; n < 12; n++) begin
      if (dn8) begin
        dones++;
        seen = q8;
      end
      step();
    end
    check("c4_done_count", dones, 1);
    check("c4_result", {24'd0, seen}, 32'h0A);

    // Case 5: reset during CALC cycle 4 aborts the transaction
    start_txn(1, 1'b1, 8'hFF);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("c5_rst_data_out", {24'd0, q8}, 32'h0);
    check("c5_rst_busy",     {31'd0, b8}, 32'h0);
    check("c5_rst_done",     {31'd0, dn8}, 32'h0);
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (dn8) dones++;
    end
    check("c5_no_done_after_abort", dones, 0);
    start_txn(1, 1'b0, 8'h5A);
    wait_done(1, 10, lat, bc);
    check("c5_recover_latency", lat, 1);
    check("c5_recover_result", {24'd0, q8}, 32'h77);

    // W=8 binary->Gray at the MSB boundary: 80 -> C0
    step();
    start_txn(1, 1'b0, 8'h80);
    wait_done(1, 10, lat, bc);
    check("w8_enc_msb_result", {24'd0, q8}, 32'hC0);

    // start held high: back-to-back W=4 decodes of 1001 -> 1110
    s4 = 1'b1; m4 = 1'b1; d4 = 4'h9;
    repeat (12) step();
    check("held_start_result", {28'd0, q4}, 32'hE);
    s4 = 1'b0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
